// File: rtl/sram_like_arbiter_2x1_pkg.sv
// Shared encodings for the 2:1 sram-like arbiter: FSM states, owner IDs and
// sram-like transfer size codes.
package sram_like_arbiter_2x1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_2x1_if.sv
// One sram-like port: the master issues req/addr/wdata, and the slave
// answers with addr_ok, data_ok and rdata.
interface sram_like_arbiter_2x1_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );

endinterface

// File: rtl/sram_like_prio_sel.sv
// Grant function: data has fixed priority unless the inst requester
// has hit its starvation limit.
module sram_like_prio_sel
    import sram_like_arbiter_2x1_pkg::*;
(
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic starve_hit_i,
    output logic grant_valid_o,
    output logic grant_owner_o
);

    always_comb begin
        grant_valid_o = inst_req_i | data_req_i;
        grant_owner_o = OWN_INST;
        if (starve_hit_i && inst_req_i) begin
            grant_owner_o = OWN_INST;
        end else if (data_req_i) begin
            grant_owner_o = OWN_DATA;
        end
    end

endmodule

// File: rtl/sram_like_arbiter_2x1.sv
// Shares one sram-like memory port between the inst and data requesters,
// allowing one outstanding transaction and routing handshakes to the owner.
module sram_like_arbiter_2x1
    import sram_like_arbiter_2x1_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    sram_like_arbiter_2x1_if.slave  inst_if,
    sram_like_arbiter_2x1_if.slave  data_if,
    sram_like_arbiter_2x1_if.master mem_if,
    output logic                    busy
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starve_hit;
    logic             grant_valid;
    logic             grant_owner;
    logic             arb_en;
    logic             owner_req;

    assign starve_hit = (starve_q == CNT_W'(STARVE_MAX));
    assign owner_req  = (owner_q == OWN_DATA) ? data_if.req : inst_if.req;
    assign busy       = (state_q != ST_IDLE);

    assign inst_if.rdata = mem_if.rdata;
    assign data_if.rdata = mem_if.rdata;

    sram_like_prio_sel u_prio_sel (
        .inst_req_i    (inst_if.req),
        .data_req_i    (data_if.req),
        .starve_hit_i  (starve_hit),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_INST;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        starve_d        = starve_q;
        arb_en          = 1'b0;
        mem_if.req      = 1'b0;
        mem_if.wr       = 1'b0;
        mem_if.size     = '0;
        mem_if.addr     = '0;
        mem_if.wdata    = '0;
        inst_if.addr_ok = 1'b0;
        inst_if.data_ok = 1'b0;
        data_if.addr_ok = 1'b0;
        data_if.data_ok = 1'b0;

        case (state_q)
            ST_REQ: begin
                mem_if.req = owner_req;
                if (owner_q == OWN_DATA) begin
                    mem_if.wr       = data_if.wr;
                    mem_if.size     = data_if.size;
                    mem_if.addr     = data_if.addr;
                    mem_if.wdata    = data_if.wdata;
                    data_if.addr_ok = mem_if.addr_ok;
                end else begin
                    mem_if.wr       = inst_if.wr;
                    mem_if.size     = inst_if.size;
                    mem_if.addr     = inst_if.addr;
                    mem_if.wdata    = inst_if.wdata;
                    inst_if.addr_ok = mem_if.addr_ok;
                end
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (mem_if.addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (owner_q == OWN_DATA) begin
                    data_if.data_ok = mem_if.data_ok;
                end else begin
                    inst_if.data_ok = mem_if.data_ok;
                end
                if (mem_if.data_ok) begin
                    arb_en  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                arb_en  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Re-arbitration on data_ok lets a back-to-back request skip IDLE.
        if (arb_en && grant_valid) begin
            state_d = ST_REQ;
            owner_d = grant_owner;
            if (grant_owner == OWN_INST) begin
                starve_d = '0;
            end else if (inst_if.req && !starve_hit) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter_2x1.sv
// Directed bench for the 2:1 sram-like arbiter with hand-computed expectations.
module tb_sram_like_arbiter_2x1;
    import sram_like_arbiter_2x1_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic busy;

    sram_like_arbiter_2x1_if inst_bus ();
    sram_like_arbiter_2x1_if data_bus ();
    sram_like_arbiter_2x1_if mem_bus ();

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    logic [31:0] t3_addr [10];
    logic [31:0] t3_cnt  [10];

    sram_like_arbiter_2x1 #(
        .STARVE_MAX (4),
        .CNT_W      (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .inst_if (inst_bus),
        .data_if (data_bus),
        .mem_if  (mem_bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_bus.req     = 1'b0;
        inst_bus.wr      = 1'b0;
        inst_bus.size    = '0;
        inst_bus.addr    = '0;
        inst_bus.wdata   = '0;
        data_bus.req     = 1'b0;
        data_bus.wr      = 1'b0;
        data_bus.size    = '0;
        data_bus.addr    = '0;
        data_bus.wdata   = '0;
        mem_bus.rdata    = '0;
        mem_bus.addr_ok  = 1'b0;
        mem_bus.data_ok  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        t3_addr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000,
                    32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000};
        t3_cnt  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0,
                    32'd1, 32'd2, 32'd3, 32'd4, 32'd0};

        idle_inputs();
        resetn = 1'b0;
        repeat (3) step();
        settle();
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_bus.req), 32'd0);
        chk("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_cnt",     32'(dut.starve_q), 32'd0);
        chk("rst_mem_addr", mem_bus.addr, 32'd0);

        // 1: lone inst read
        step();
        resetn = 1'b1;
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000; inst_bus.size = SIZE_WORD;
        settle();
        chk("t1_no_fwd", 32'(mem_bus.req), 32'd0);
        step(); settle();
        chk("t1_mem_req",  32'(mem_bus.req), 32'd1);
        chk("t1_mem_addr", mem_bus.addr, 32'hBFC0_0000);
        chk("t1_mem_size", 32'(mem_bus.size), 32'd2);
        chk("t1_aok_early", 32'(inst_bus.addr_ok), 32'd0);
        step(); settle();
        chk("t1_state_req", 32'(dut.state_q), 32'(ST_REQ));
        step(); mem_bus.addr_ok = 1'b1; settle();
        chk("t1_inst_aok", 32'(inst_bus.addr_ok), 32'd1);
        chk("t1_data_aok", 32'(data_bus.addr_ok), 32'd0);
        step(); mem_bus.addr_ok = 1'b0; inst_bus.req = 1'b0; settle();
        chk("t1_wait_req",   32'(mem_bus.req), 32'd0);
        chk("t1_state_wait", 32'(dut.state_q), 32'(ST_WAIT));
        chk("t1_wait_busy",  32'(busy), 32'd1);
        step(); settle();
        step(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h3C1D_BFC0; settle();
        chk("t1_inst_dok",   32'(inst_bus.data_ok), 32'd1);
        chk("t1_inst_rdata", inst_bus.rdata, 32'h3C1D_BFC0);
        chk("t1_data_dok",   32'(data_bus.data_ok), 32'd0);
        step(); mem_bus.data_ok = 1'b0; settle();
        chk("t1_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t1_busy_end",   32'(busy), 32'd0);

        // 2: simultaneous requests, data write wins
        step();
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0004; inst_bus.size = SIZE_WORD;
        data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = SIZE_WORD;
        data_bus.addr = 32'h0000_0100; data_bus.wdata = 32'h1234_5678;
        settle();
        chk("t2_no_fwd", 32'(mem_bus.req), 32'd0);
        step(); mem_bus.addr_ok = 1'b1; settle();
        chk("t2_d_mem_req", 32'(mem_bus.req), 32'd1);
        chk("t2_d_wr",      32'(mem_bus.wr), 32'd1);
        chk("t2_d_addr",    mem_bus.addr, 32'h0000_0100);
        chk("t2_d_wdata",   mem_bus.wdata, 32'h1234_5678);
        chk("t2_d_aok",     32'(data_bus.addr_ok), 32'd1);
        chk("t2_i_aok",     32'(inst_bus.addr_ok), 32'd0);
        chk("t2_cnt1",      32'(dut.starve_q), 32'd1);
        step(); mem_bus.addr_ok = 1'b0; data_bus.req = 1'b0; settle();
        chk("t2_state_wait", 32'(dut.state_q), 32'(ST_WAIT));
        step(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hAAAA_5555; settle();
        chk("t2_d_dok",   32'(data_bus.data_ok), 32'd1);
        chk("t2_d_rdata", data_bus.rdata, 32'hAAAA_5555);
        chk("t2_i_dok",   32'(inst_bus.data_ok), 32'd0);
        chk("t2_gap_req", 32'(mem_bus.req), 32'd0);
        step(); mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1; settle();
        chk("t2_i_mem_req", 32'(mem_bus.req), 32'd1);
        chk("t2_i_addr",    mem_bus.addr, 32'hBFC0_0004);
        chk("t2_i_wr",      32'(mem_bus.wr), 32'd0);
        chk("t2_i_wdata",   mem_bus.wdata, 32'd0);
        chk("t2_i_aok2",    32'(inst_bus.addr_ok), 32'd1);
        chk("t2_cnt0",      32'(dut.starve_q), 32'd0);
        step(); mem_bus.addr_ok = 1'b0; inst_bus.req = 1'b0; mem_bus.data_ok = 1'b1; settle();
        chk("t2_i_dok2", 32'(inst_bus.data_ok), 32'd1);
        step(); mem_bus.data_ok = 1'b0; settle();
        chk("t2_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // 3: starvation, both requesters held high
        step();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_1000;
        data_bus.req = 1'b1; data_bus.addr = 32'h0000_2000; data_bus.wr = 1'b0;
        data_bus.wdata = '0;
        settle();
        for (int i = 0; i < 10; i++) begin
            step(); mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1; settle();
            chk($sformatf("t3_addr%0d", i), mem_bus.addr, t3_addr[i]);
            chk($sformatf("t3_cnt%0d", i), 32'(dut.starve_q), t3_cnt[i]);
            chk($sformatf("t3_aok%0d", i), 32'({inst_bus.addr_ok, data_bus.addr_ok}),
                (t3_addr[i] == 32'h1000) ? 32'd2 : 32'd1);
            step(); mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
            if (i == 9) begin
                inst_bus.req = 1'b0;
                data_bus.req = 1'b0;
            end
            settle();
            chk($sformatf("t3_dok%0d", i), 32'({inst_bus.data_ok, data_bus.data_ok}),
                (t3_addr[i] == 32'h1000) ? 32'd2 : 32'd1);
        end
        step(); mem_bus.data_ok = 1'b0; settle();
        chk("t3_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // 4: owner re-request on its own data_ok
        step(); data_bus.req = 1'b1; data_bus.addr = 32'h0000_0300; settle();
        chk("t4_no_fwd", 32'(mem_bus.req), 32'd0);
        step(); mem_bus.addr_ok = 1'b1; settle();
        chk("t4_aok", 32'(data_bus.addr_ok), 32'd1);
        step(); mem_bus.addr_ok = 1'b0; data_bus.req = 1'b0; settle();
        step(); mem_bus.data_ok = 1'b1; data_bus.req = 1'b1; data_bus.addr = 32'h0000_0304; settle();
        chk("t4_dok",  32'(data_bus.data_ok), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        step(); mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1; settle();
        chk("t4_state_req", 32'(dut.state_q), 32'(ST_REQ));
        chk("t4_mem_req",   32'(mem_bus.req), 32'd1);
        chk("t4_mem_addr",  mem_bus.addr, 32'h0000_0304);

        // 5: reset while waiting, then a stale data_ok
        step(); mem_bus.addr_ok = 1'b0; data_bus.req = 1'b0; resetn = 1'b0; settle();
        chk("t5_state_wait", 32'(dut.state_q), 32'(ST_WAIT));
        step(); resetn = 1'b1; settle();
        chk("t5_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t5_busy",       32'(busy), 32'd0);
        chk("t5_owner",      32'(dut.owner_q), 32'(OWN_INST));
        step(); mem_bus.data_ok = 1'b1; settle();
        chk("t5_d_dok",    32'(data_bus.data_ok), 32'd0);
        chk("t5_i_dok",    32'(inst_bus.data_ok), 32'd0);
        chk("t5_busy2",    32'(busy), 32'd0);
        chk("t5_mem_req",  32'(mem_bus.req), 32'd0);
        step(); mem_bus.data_ok = 1'b0; settle();
        chk("t5_state_end", 32'(dut.state_q), 32'(ST_IDLE));

        // 6: owner withdraws before addr_ok; stray addr_ok in IDLE
        step(); inst_bus.req = 1'b1; inst_bus.addr = 32'h2000_0040; settle();
        step(); settle();
        chk("t6_mem_req", 32'(mem_bus.req), 32'd1);
        step(); inst_bus.req = 1'b0; settle();
        chk("t6_req_drop", 32'(mem_bus.req), 32'd0);
        chk("t6_no_aok",   32'(inst_bus.addr_ok), 32'd0);
        step(); mem_bus.addr_ok = 1'b1; settle();
        chk("t6_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t6_busy",       32'(busy), 32'd0);
        chk("t6_stray_aok",  32'({inst_bus.addr_ok, data_bus.addr_ok}), 32'd0);
        chk("t6_mem_addr",   mem_bus.addr, 32'd0);
        step(); mem_bus.addr_ok = 1'b0; settle();
        chk("t6_state_end", 32'(dut.state_q), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
